// File: rtl/registers_mp.sv
// registers_mp: multi-port integer register file with two write lanes
// (ALU = port A, LSU = port B), combinational read ports, optional
// write-to-read bypass and a per-register busy scoreboard for decode stalls.
module registers_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned DEPTH   = 1 << ADDR_W
) (
    input  logic                     clk_w_i,
    input  logic                     res_w_i_l,
    input  logic [NUM_RD*ADDR_W-1:0] rd_reg_w_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_w_o,
    output logic [NUM_RD-1:0]        rd_busy_w_o,
    input  logic [ADDR_W-1:0]        wr_reg_a_w_i,
    input  logic [DATA_W-1:0]        wr_data_a_w_i,
    input  logic                     reg_wr_flag_a_w_i,
    input  logic [ADDR_W-1:0]        wr_reg_b_w_i,
    input  logic [DATA_W-1:0]        wr_data_b_w_i,
    input  logic                     reg_wr_flag_b_w_i,
    input  logic                     busy_set_flag_w_i,
    input  logic [ADDR_W-1:0]        busy_set_reg_w_i,
    output logic [DEPTH-1:0]         busy_vec_w_o
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  busy_nxt_s;
    logic              wr_a_en_s;
    logic              wr_b_en_s;

    // Qualify storage writes: the hardwired zero register is never written.
    always_comb begin
        wr_a_en_s = 1'b0;
        wr_b_en_s = 1'b0;
        if (ZERO_REG && (wr_reg_a_w_i == {ADDR_W{1'b0}})) begin
            wr_a_en_s = 1'b0;
        end else begin
            wr_a_en_s = reg_wr_flag_a_w_i;
        end
        if (ZERO_REG && (wr_reg_b_w_i == {ADDR_W{1'b0}})) begin
            wr_b_en_s = 1'b0;
        end else begin
            wr_b_en_s = reg_wr_flag_b_w_i;
        end
    end

    // Register storage; port B is applied last so it wins an address collision.
    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        if (!res_w_i_l) begin
            for (int unsigned n = 0; n < DEPTH; n++) begin
                mem_r[n] <= {DATA_W{1'b0}};
            end
        end else begin
            if (wr_a_en_s) begin
                mem_r[wr_reg_a_w_i] <= wr_data_a_w_i;
            end
            if (wr_b_en_s) begin
                mem_r[wr_reg_b_w_i] <= wr_data_b_w_i;
            end
        end
    end

    // Next scoreboard state: a new producer (set) overrides a retiring one (clear).
    always_comb begin
        busy_nxt_s = busy_r;
        for (int unsigned n = 0; n < DEPTH; n++) begin
            if (busy_set_flag_w_i && (busy_set_reg_w_i == ADDR_W'(n))) begin
                busy_nxt_s[n] = 1'b1;
            end else if ((reg_wr_flag_a_w_i && (wr_reg_a_w_i == ADDR_W'(n))) ||
                         (reg_wr_flag_b_w_i && (wr_reg_b_w_i == ADDR_W'(n)))) begin
                busy_nxt_s[n] = 1'b0;
            end else begin
                busy_nxt_s[n] = busy_r[n];
            end
        end
        if (ZERO_REG) begin
            busy_nxt_s[0] = 1'b0;
        end else begin
            busy_nxt_s[0] = busy_nxt_s[0];
        end
    end

    // Registered busy scoreboard.
    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        if (!res_w_i_l) begin
            busy_r <= {DEPTH{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign busy_vec_w_o = busy_r;

    // Combinational read ports with optional same-cycle bypass (B over A);
    // outputs are forced to zero while reset is held.
    always_comb begin
        logic [ADDR_W-1:0] addr_v;
        logic [DATA_W-1:0] val_v;
        rd_data_w_o = {(NUM_RD*DATA_W){1'b0}};
        rd_busy_w_o = {NUM_RD{1'b0}};
        addr_v      = {ADDR_W{1'b0}};
        val_v       = {DATA_W{1'b0}};
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            addr_v = rd_reg_w_i[k*ADDR_W +: ADDR_W];
            if (BYPASS && reg_wr_flag_b_w_i && (wr_reg_b_w_i == addr_v)) begin
                val_v = wr_data_b_w_i;
            end else if (BYPASS && reg_wr_flag_a_w_i && (wr_reg_a_w_i == addr_v)) begin
                val_v = wr_data_a_w_i;
            end else begin
                val_v = mem_r[addr_v];
            end
            if (!res_w_i_l || (ZERO_REG && (addr_v == {ADDR_W{1'b0}}))) begin
                val_v = {DATA_W{1'b0}};
            end else begin
                val_v = val_v;
            end
            rd_data_w_o[k*DATA_W +: DATA_W] = val_v;
            if (res_w_i_l) begin
                rd_busy_w_o[k] = busy_r[addr_v];
            end else begin
                rd_busy_w_o[k] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_registers_mp.sv
// Self-checking bench for registers_mp: one bypassing and one non-bypassing
// instance driven by identical stimulus, compared to a behavioural model.
module tb_registers_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR*AW-1:0] rd_reg;
    logic [NR*DW-1:0] rd_data_byp, rd_data_nob;
    logic [NR-1:0]    rd_busy_byp, rd_busy_nob;
    logic [DEPTH-1:0] bv_byp, bv_nob;
    logic [AW-1:0]    wa, wb, sr;
    logic [DW-1:0]    da, db;
    logic             fa, fb, fs;

    registers_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_byp (
        .clk_w_i(clk), .res_w_i_l(rst_n), .rd_reg_w_i(rd_reg), .rd_data_w_o(rd_data_byp),
        .rd_busy_w_o(rd_busy_byp), .wr_reg_a_w_i(wa), .wr_data_a_w_i(da), .reg_wr_flag_a_w_i(fa),
        .wr_reg_b_w_i(wb), .wr_data_b_w_i(db), .reg_wr_flag_b_w_i(fb),
        .busy_set_flag_w_i(fs), .busy_set_reg_w_i(sr), .busy_vec_w_o(bv_byp));

    registers_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_nob (
        .clk_w_i(clk), .res_w_i_l(rst_n), .rd_reg_w_i(rd_reg), .rd_data_w_o(rd_data_nob),
        .rd_busy_w_o(rd_busy_nob), .wr_reg_a_w_i(wa), .wr_data_a_w_i(da), .reg_wr_flag_a_w_i(fa),
        .wr_reg_b_w_i(wb), .wr_data_b_w_i(db), .reg_wr_flag_b_w_i(fb),
        .busy_set_flag_w_i(fs), .busy_set_reg_w_i(sr), .busy_vec_w_o(bv_nob));

    // Reference model state
    logic [DW-1:0] m_mem  [DEPTH];
    logic          m_busy [DEPTH];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
        if (!rst_n || a == 0) return '0;
        if (byp && fb && wb == a) return db;
        if (byp && fa && wa == a) return da;
        return m_mem[a];
    endfunction

    function automatic logic [DEPTH-1:0] exp_bv();
        logic [DEPTH-1:0] v;
        for (int n = 0; n < DEPTH; n++) v[n] = m_busy[n];
        return v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < DEPTH; n++) begin
            m_mem[n]  = '0;
            m_busy[n] = 1'b0;
        end
    endtask

    // One clock edge of the architectural behaviour.
    task automatic model_edge();
        logic nb [DEPTH];
        for (int n = 0; n < DEPTH; n++) begin
            nb[n] = m_busy[n];
            if ((fa && wa == n) || (fb && wb == n)) nb[n] = 1'b0;
            if (fs && sr == n) nb[n] = 1'b1;
            if (n == 0) nb[n] = 1'b0;
        end
        for (int n = 0; n < DEPTH; n++) m_busy[n] = nb[n];
        if (fa && wa != 0) m_mem[wa] = da;
        if (fb && wb != 0) m_mem[wb] = db;
    endtask

    task automatic check_outputs(input string tag);
        logic [AW-1:0] a;
        for (int k = 0; k < NR; k++) begin
            a = rd_reg[k*AW +: AW];
            chk($sformatf("%s_byp_data%0d", tag, k), 64'(rd_data_byp[k*DW +: DW]), 64'(exp_read(a, 1'b1)));
            chk($sformatf("%s_nob_data%0d", tag, k), 64'(rd_data_nob[k*DW +: DW]), 64'(exp_read(a, 1'b0)));
            chk($sformatf("%s_byp_busy%0d", tag, k), 64'(rd_busy_byp[k]), 64'(rst_n ? m_busy[a] : 1'b0));
            chk($sformatf("%s_nob_busy%0d", tag, k), 64'(rd_busy_nob[k]), 64'(rst_n ? m_busy[a] : 1'b0));
        end
        chk({tag, "_byp_vec"}, 64'(bv_byp), 64'(exp_bv()));
        chk({tag, "_nob_vec"}, 64'(bv_nob), 64'(exp_bv()));
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle(input string tag);
        #1;
        check_outputs({tag, "_pre"});
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        check_outputs({tag, "_post"});
        @(negedge clk);
    endtask

    task automatic idle();
        fa = 1'b0; fb = 1'b0; fs = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, a1, a2, a3);
        rd_reg = {a3, a2, a1, a0};
    endtask

    initial begin
        idle();
        wa = '0; wb = '0; sr = '0; da = '0; db = '0;
        set_rd(5'd0, 5'd31, 5'd0, 5'd31);
        model_reset();

        // 1. reset held three cycles, then read r0 / r31
        @(negedge clk);
        repeat (3) cycle("t1_rst");
        rst_n = 1'b1;
        #1;
        chk("t1_r0", 64'(rd_data_byp[31:0]), 64'h0);
        chk("t1_r31", 64'(rd_data_nob[63:32]), 64'h0);
        chk("t1_busy", 64'(rd_busy_byp), 64'h0);
        chk("t1_vec", 64'(bv_byp), 64'h0);
        cycle("t1_read");

        // 2. dual-write collision on r5
        fa = 1'b1; wa = 5'd5; da = 32'h1111_1111;
        fb = 1'b1; wb = 5'd5; db = 32'h2222_2222;
        set_rd(5'd5, 5'd5, 5'd0, 5'd31);
        #1;
        chk("t2_byp_same0", 64'(rd_data_byp[31:0]), 64'h2222_2222);
        chk("t2_byp_same1", 64'(rd_data_byp[63:32]), 64'h2222_2222);
        chk("t2_nob_same0", 64'(rd_data_nob[31:0]), 64'h0);
        cycle("t2_wr");
        idle();
        #1;
        chk("t2_byp_next", 64'(rd_data_byp[31:0]), 64'h2222_2222);
        chk("t2_nob_next", 64'(rd_data_nob[31:0]), 64'h2222_2222);
        cycle("t2_after");

        // 3. zero register write + busy set
        fb = 1'b1; wb = 5'd0; db = 32'hDEAD_BEEF; fs = 1'b1; sr = 5'd0;
        set_rd(5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("t3_byp_same", 64'(rd_data_byp), 64'h0);
        chk("t3_nob_same", 64'(rd_data_nob), 64'h0);
        cycle("t3_wr");
        chk("t3_vec0", 64'(bv_byp[0]), 64'h0);
        idle();
        #1;
        chk("t3_byp_next", 64'(rd_data_byp), 64'h0);
        cycle("t3_after");

        // 4. scoreboard set / clear / simultaneous set+write on r7
        fs = 1'b1; sr = 5'd7;
        set_rd(5'd7, 5'd7, 5'd3, 5'd0);
        cycle("t4_set");
        idle();
        #1;
        chk("t4_vec7_set", 64'(bv_byp[7]), 64'h1);
        chk("t4_rdbusy_set", 64'(rd_busy_byp[0]), 64'h1);
        cycle("t4_n1");
        cycle("t4_n2");
        fb = 1'b1; wb = 5'd7; db = 32'h0000_00AA;
        #1;
        chk("t4_busy_not_bypassed", 64'(rd_busy_byp[0]), 64'h1);
        chk("t4_byp_data_same", 64'(rd_data_byp[31:0]), 64'hAA);
        cycle("t4_wr");
        idle();
        #1;
        chk("t4_vec7_clr", 64'(bv_nob[7]), 64'h0);
        chk("t4_data_aa", 64'(rd_data_nob[31:0]), 64'hAA);
        cycle("t4_n4");
        fs = 1'b1; sr = 5'd7; fb = 1'b1; wb = 5'd7; db = 32'h0000_00BB;
        cycle("t4_both");
        idle();
        #1;
        chk("t4_vec7_both", 64'(bv_byp[7]), 64'h1);
        chk("t4_data_bb", 64'(rd_data_nob[31:0]), 64'hBB);
        cycle("t4_after");

        // 5. fill r1..r31, set some busy bits, then async reset between edges
        for (int r = 1; r < DEPTH; r++) begin
            fa = 1'b1; wa = AW'(r); da = $urandom;
            fs = (r % 4 == 1); sr = AW'(($urandom_range(31, 0) + r) % DEPTH);
            cycle("t5_fill");
        end
        idle();
        set_rd(5'd4, 5'd8, 5'd12, 5'd31);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_vec", 64'(bv_byp), 64'h0);
        chk("t5_rst_data", 64'(rd_data_nob), 64'h0);
        check_outputs("t5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("t5_after");

        // 6. random regression
        for (int i = 0; i < 10000; i++) begin
            fa = 1'($urandom); fb = 1'($urandom); fs = ($urandom_range(3, 0) == 0);
            wa = AW'($urandom); da = $urandom; db = $urandom;
            wb = ($urandom_range(3, 0) == 0) ? wa : AW'($urandom);
            sr = ($urandom_range(2, 0) == 0) ? wb : AW'($urandom);
            set_rd(wa, wb, AW'($urandom), AW'($urandom));
            cycle("t6");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
